// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port (1-cycle read latency) between fetch and load/store requesters.
// Optional fairness limiter enabled by defining ARB_FAIR_EN; default build is strict data-over-inst.
module sram_port_arbiter #(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [31:0] stall_cnt,
  output logic [1:0]  dbg_owner
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_bad_streak_max
    $error("sram_port_arbiter: STREAK_MAX must be in 1..15");
  end

  owner_e      r_owner;
  owner_e      w_owner_nxt;
  logic        w_force_inst;
  logic        w_gnt_data;
  logic        w_gnt_inst;
  logic [31:0] r_stall_cnt;

  // Handshake: a request is accepted in the cycle its addr_ok is high; data_ok follows exactly one cycle later.
  assign w_gnt_data = resetn && data_req && !(inst_req && w_force_inst);
  assign w_gnt_inst = resetn && inst_req && !w_gnt_data;

`ifdef ARB_FAIR_EN
  localparam logic [3:0] LP_STREAK_MAX = 4'(STREAK_MAX);
  logic [3:0] r_streak;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_streak <= 4'd0;
    end else if (!inst_req || w_gnt_inst) begin
      r_streak <= 4'd0;
    end else if (w_gnt_data && (r_streak != LP_STREAK_MAX)) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  assign w_force_inst = (r_streak == LP_STREAK_MAX);
`else
  assign w_force_inst = 1'b0;
`endif

  assign inst_addr_ok = w_gnt_inst;
  assign data_addr_ok = w_gnt_data;
  assign sram_en      = w_gnt_inst | w_gnt_data;
  assign sram_addr    = w_gnt_data ? data_addr : inst_addr;
  assign sram_we      = (w_gnt_data && data_wr) ? data_wstrb : 4'h0;
  assign sram_wdata   = data_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_gnt_data) begin
      w_owner_nxt = OWN_DATA;
    end else if (w_gnt_inst) begin
      w_owner_nxt = OWN_INST;
    end
  end

  // Response routing; resetn gating drops any in-flight response the moment reset asserts.
  always_comb begin
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    if (resetn) begin
      case (r_owner)
        OWN_INST: begin
          inst_data_ok = 1'b1;
          inst_rdata   = sram_rdata;
        end
        OWN_DATA: begin
          data_data_ok = 1'b1;
          data_rdata   = sram_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= 32'd0;
    end else if (inst_req && !w_gnt_inst) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign dbg_owner = r_owner;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single synchronous data SRAM port between the instruction-fetch requester and the EXE-stage load/store requester. Requests use a req/addr_ok/data_ok handshake, and the SRAM has a fixed 1-cycle read latency. The block arbitrates one request per cycle, tracks which requester owns the in-flight access, and routes the response back to that owner. An optional fairness limiter bounds instruction-fetch starvation.

## Interface
- `STREAK_MAX`, default 4: maximum consecutive data grants taken while `inst_req` is waiting (range 1..15).
- `clk` in 1: clock. All state updates on the rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `inst_req` in 1: fetch request (read only).
- `inst_addr` in 32: fetch byte address.
- `inst_addr_ok` out 1: fetch request accepted this cycle.
- `inst_data_ok` out 1: fetch response valid.
- `inst_rdata` out 32: fetch data.
- `data_req` in 1: load/store request.
- `data_wr` in 1: 1 = store.
- `data_wstrb` in 4: store byte enables.
- `data_addr` in 32: data byte address.
- `data_wdata` in 32: store data.
- `data_addr_ok` out 1: data request accepted this cycle.
- `data_data_ok` out 1: data response valid (loads and stores).
- `data_rdata` out 32: load data.
- `sram_en` out 1: SRAM enable.
- `sram_we` out 4: SRAM byte write enables.
- `sram_addr` out 32: SRAM address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid 1 cycle after `sram_en`.
- `stall_cnt` out 32: cycles with `inst_req` high and `inst_addr_ok` low.

## Operation
- Grant is combinational and produces at most one grant per cycle.
  - `gnt_data` = `data_req` && !(`inst_req` && force_inst).
  - `gnt_inst` = `inst_req` && !`gnt_data`.
- Default priority: data over inst.
- `inst_addr_ok` = `gnt_inst`; `data_addr_ok` = `gnt_data`.
- SRAM mux:
  - `sram_en` = `gnt_inst` | `gnt_data`.
  - `sram_addr` comes from the granted requester.
  - `sram_we` = `gnt_data` && `data_wr` ? `data_wstrb` : 4'h0.
  - `sram_wdata` = `data_wdata`.
- Requesters hold req/addr/wdata stable until they see addr_ok.
- Owner FSM (registered). States: NONE, INST, DATA.
  - Next state = DATA if `gnt_data`, else INST if `gnt_inst`, else NONE.
  - State INST: `inst_data_ok` = 1 and `inst_rdata` = `sram_rdata`.
  - State DATA: `data_data_ok` = 1 and `data_rdata` = `sram_rdata`.
  - In every other case the response outputs are 0.
- Responses cannot be back-pressured; requesters must accept the response in the cycle it is presented.
- A back-to-back accept every cycle is legal. The response for the grant in cycle N appears in cycle N+1, concurrently with the grant for cycle N+1.
- Streak counter, 4 bits, saturating at `STREAK_MAX`:
  - +1 on a cycle with `gnt_data` && `inst_req`.
  - Cleared on `gnt_inst` or on any cycle with `inst_req` low.
- force_inst = (streak == `STREAK_MAX`).
- `stall_cnt`: +1 each cycle with `inst_req` && !`gnt_inst`. Wraps modulo 2^32.

## Timing
- Address phase: 0-cycle latency from req to addr_ok when granted.
- Data phase: data_ok exactly 1 cycle after addr_ok, for both reads and writes.
- Sustained throughput: 1 access per cycle.
- Reset, asserted asynchronously:
  - Owner goes to NONE; streak and `stall_cnt` go to 0.
  - All addr_ok, data_ok, rdata, `sram_en` and `sram_we` outputs are forced to 0 while `resetn` is low.
- Reset mid-access: the in-flight response is dropped, and no data_ok is issued after reset is released.
- Simultaneous requests with force_inst = 1: inst is granted and streak clears in the same edge.
- `inst_req` dropping while starved (illegal, but tolerated): streak clears and no grant is issued for inst.

## Configuration
- `ARB_FAIR_EN` defined: the streak counter and force_inst are as specified above.
- `ARB_FAIR_EN` undefined:
  - Streak logic is removed and force_inst = 0.
  - Priority is strictly data over inst, so unbounded inst starvation is possible.
  - `stall_cnt` is still present.

## Test plan
- Single fetch, `inst_addr`=0x1C000000, SRAM holds 0x02800C0C at that word:
  - `inst_addr_ok`=1 in cycle 0.
  - `inst_data_ok`=1 and `inst_rdata`=0x02800C0C in cycle 1.
  - `data_data_ok`=0.
- Store then load at 0x100:
  - Store: `data_wr`=1, `wstrb`=4'hF, `wdata`=0xDEADBEEF. Expect `sram_we`=4'hF in the grant cycle and `data_data_ok`=1 the next cycle.
  - Load from 0x100 next: `data_rdata`=0xDEADBEEF one cycle after its grant.
- Simultaneous requests for 10 cycles with `ARB_FAIR_EN` defined and `STREAK_MAX`=4:
  - Grants follow D,D,D,D,I,D,D,D,D,I.
  - `stall_cnt`=8.
  - Each data_ok is routed to the matching owner.
- Same stimulus as the previous scenario with `ARB_FAIR_EN` undefined:
  - 10 data grants, 0 inst grants.
  - `stall_cnt`=10.
- Reset mid-access: deassert `resetn` in the cycle after a fetch grant.
  - `inst_data_ok` goes to 0 immediately.
  - After release, with no requests for 3 cycles: all data_ok stay 0 and `stall_cnt`=0.
